// File: rtl/load_store_unit.sv
// load_store_unit: bridges the CPU execute/memory stage and a 16-byte
// big-endian data RAM. One request at a time is accepted over valid/ready.
// The unit sequences the RAM's CS/RW_/addr/data_in, registers the read data,
// and returns a held response. A range fault is reported without a RAM access.
//
// Optional feature: define BYTE_ACCESS_EN to honour req_byte_i. Byte loads
// return the addressed byte zero-extended. Byte stores run a read-modify-write.
// When BYTE_ACCESS_EN is undefined, every access is a word access.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_valid_i       CPU request present
//   req_ready_o       unit can accept (IDLE only)
//   req_we_i          1 = store, 0 = load
//   req_byte_i        byte access (BYTE_ACCESS_EN only)
//   req_addr_i        byte address
//   req_wdata_i       store data (byte stores use [7:0])
//   resp_valid_o      response available
//   resp_ready_i      CPU accepts the response
//   resp_rdata_o      load data, 0 for stores and faults
//   resp_err_o        range fault
//   mem_cs_o          RAM chip select
//   mem_rw__o         RAM RW_, 1 = read, 0 = write
//   mem_addr_o        RAM address
//   mem_wdata_o       RAM write data
//   mem_rdata_i       RAM read data (high-Z when not selected)
//
// State | meaning
// IDLE  | waiting for a request, req_ready_o = 1
// RD    | RAM read cycle (load, or first half of a byte store)
// WR    | RAM write cycle, commits on the edge ending WR
// RESP  | response held until resp_ready_i
module load_store_unit #(
  parameter int ADDR_MAX = 14,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic              req_byte_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [15:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [15:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_cs_o,
  output logic              mem_rw__o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  input  logic [15:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(ADDR_MAX);
  localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(ADDR_MAX + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;    // word base actually driven to the RAM
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic accept;
  logic byte_req;
  logic legal;

`ifdef BYTE_ACCESS_EN
  logic        byte_q, byte_d;
  logic        lo_q, lo_d;              // addressed byte is the low byte of the base word
  logic [15:0] merge_q, merge_d;
  logic [15:0] wr_word;

  assign byte_req = req_byte_i;
  assign wr_word  = !byte_q ? wdata_q :
                    lo_q    ? {merge_q[15:8], wdata_q[7:0]} :
                              {wdata_q[7:0], merge_q[7:0]};
`else
  logic        unused_byte;
  logic [15:0] wr_word;

  assign byte_req    = 1'b0;
  assign unused_byte = req_byte_i;
  assign wr_word     = wdata_q;
`endif

  assign req_ready_o  = (state_q == IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign legal        = byte_req ? (req_addr_i <= BYTE_LIMIT) : (req_addr_i <= WORD_LIMIT);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef BYTE_ACCESS_EN
      byte_q  <= 1'b0;
      lo_q    <= 1'b0;
      merge_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef BYTE_ACCESS_EN
      byte_q  <= byte_d;
      lo_q    <= lo_d;
      merge_q <= merge_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BYTE_ACCESS_EN
    byte_d  = byte_q;
    lo_d    = lo_q;
    merge_d = merge_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          we_d    = req_we_i;
          rdata_d = '0;
          err_d   = !legal;
`ifdef BYTE_ACCESS_EN
          byte_d  = req_byte_i;
          lo_d    = 1'b0;
          // The last byte has no successor, so it is reached as the low byte of the previous word.
          if (req_byte_i && (req_addr_i == BYTE_LIMIT)) begin
            addr_d = req_addr_i - ADDR_W'(1);
            lo_d   = 1'b1;
          end
`endif
          if (!legal)                    state_d = RESP;
          else if (req_we_i && !byte_req) state_d = WR;
          else                           state_d = RD;
        end
      end
      RD: begin
`ifdef BYTE_ACCESS_EN
        if (byte_q && we_q) begin
          merge_d = mem_rdata_i;
          state_d = WR;
        end else begin
          if (byte_q) rdata_d = {8'h00, lo_q ? mem_rdata_i[7:0] : mem_rdata_i[15:8]};
          else        rdata_d = mem_rdata_i;
          state_d = RESP;
        end
`else
        rdata_d = mem_rdata_i;
        state_d = RESP;
`endif
      end
      WR:      state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM drive is decoded from the state register only, so it drops with the async reset.
  always_comb begin
    mem_cs_o    = 1'b0;
    mem_rw__o   = 1'b1;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      RD: begin
        mem_cs_o   = 1'b1;
        mem_addr_o = addr_q;
      end
      WR: begin
        mem_cs_o    = 1'b1;
        mem_rw__o   = 1'b0;
        mem_addr_o  = addr_q;
        mem_wdata_o = wr_word;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute/memory stage and the 16-byte big-endian data RAM.
- Accepts one load or store request at a time over a valid/ready handshake and sequences the RAM's CS, RW_, addr and data_in.
- Captures the RAM's combinational read data and returns a registered response, or flags a range fault.

Parameters:
- ADDR_MAX, 14, highest legal word address (word spans addr and addr+1; RAM holds bytes 0..15).
- ADDR_W, 16, width of the CPU-side and RAM-side address.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  byte access; used only with BYTE_ACCESS_EN, otherwise treated as 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  16  store data; byte stores use [7:0].
- resp_valid  out  1  response available.
- resp_ready  in  1  CPU accepts the response.
- resp_rdata  out  16  load data; 0 for stores and faults.
- resp_err  out  1  range fault on this request.
- mem_cs  out  1  to RAM CS.
- mem_rw_  out  1  to RAM RW_; 1 = read, 0 = write.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_wdata  out  16  to RAM data_in.
- mem_rdata  in  16  from RAM data_out; high-Z when not selected.

Behaviour:
- States are IDLE, RD, WR and RESP. All request fields are latched on acceptance (req_valid && req_ready).
- Reset values:
  - State is IDLE and req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_cs=0, mem_rw_=1, mem_addr=0, mem_wdata=0.
- Inactive RAM drive: whenever mem_cs=0, mem_rw_=1 and mem_addr and mem_wdata are 0. mem_rdata is never sampled while mem_cs=0, so Z/X on it must not propagate.
- Range check at acceptance:
  - Word access is legal iff addr <= ADDR_MAX.
  - Byte access is legal iff addr <= ADDR_MAX+1.
  - Illegal access goes IDLE->RESP with resp_err=1, resp_rdata=0 and no mem_cs pulse.
- Word load:
  - IDLE->RD.
  - In RD: mem_cs=1, mem_rw_=1, mem_addr=latched addr. resp_rdata is registered from mem_rdata at the end of RD.
  - RD->RESP. resp_valid rises 2 cycles after the accept edge.
- Word store:
  - IDLE->WR.
  - In WR: mem_cs=1, mem_rw_=0, mem_addr=addr, mem_wdata=wdata, for exactly one cycle. The RAM commits on the edge ending WR.
  - WR->RESP, with resp_rdata=0.
- RESP: resp_valid=1 and the response is held stable until resp_ready. On the edge where resp_ready=1, go RESP->IDLE and resp_valid falls. resp_ready is ignored outside RESP.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP. There is no accept in the same cycle as a response handoff.
- No pipelining: exactly one outstanding request.
- Reset mid-operation: all state returns to IDLE and mem_cs drops immediately, asynchronously. A store interrupted during WR is not guaranteed to have committed. Any pending response is discarded.

Optional Feature:
- Macro: BYTE_ACCESS_EN.
- Defined: req_byte is honoured.
  - Word base is addr, or addr-1 when addr == ADDR_MAX+1. The selected byte is the high byte at base == addr, or the low byte when base == addr-1.
  - Byte load: IDLE->RD->RESP. resp_rdata is the selected byte zero-extended to 16 bits.
  - Byte store (read-modify-write): IDLE->RD->WR->RESP.
    - RD reads the base word into an internal register.
    - WR writes the merged word: the selected byte is replaced by wdata[7:0] and the other byte is preserved.
    - resp_valid rises 3 cycles after accept.
- Undefined: req_byte is ignored, no merge logic exists, and all accesses are word accesses.

Test Plan:
- Reset with rst_n=0 mid-RD -> mem_cs=0 asynchronously; after release req_ready=1, resp_valid=0, mem_rw_=1.
- Store 0xBEEF @4 then load @4 -> store response err=0 at accept+2; load resp_rdata=0xBEEF; RAM bytes [4]=0xBE, [5]=0xEF; exactly one mem_cs cycle per access.
- Load @14 after storing 0x1234 @14 -> 0x1234, err=0. Load @15 -> resp_err=1, rdata=0, mem_cs never asserted.
- resp_ready held low 5 cycles after a load -> resp_valid and resp_rdata stable throughout; req_valid asserted meanwhile is not accepted (req_ready=0).
- BYTE_ACCESS_EN:
  - Preload 0xAABB @14.
  - Byte store 0x5C @15 -> RD then WR at mem_addr=14 with mem_wdata=0xAA5C.
  - Byte load @14 -> 0x00AA.
  - Byte load @16 -> err=1.
- Without BYTE_ACCESS_EN: req_byte=1 store 0x5C5C @2 -> full word 0x5C5C written @2, latency as a word store.
